// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core.
// Walks each instruction through FETCH, DECODE, EXEC, optional EXEC_WAIT/MEM,
// and WB, with data-memory timeout and illegal-instruction trapping.
//
// Ports:
//   clk, rst                 core clock, async active-high reset
//   instr_valid, opcode,
//   fun3, fun7               fetched instruction fields (latched in FETCH)
//   dmem_ready, alu_done,
//   br_taken                 handshakes / branch result
//   instr_req, pc_en, next_sel, jalr_out, branch          fetch/PC control
//   reg_write, operand_a, operand_b, imm_sel, mem_to_reg,
//   alu_control, alu_start                                 datapath control
//   mem_req, mem_we                                        data-memory request
//   illegal_instr, bus_error                               trap/error pulses
//
// state     | meaning
// ----------+--------------------------------------------------------
// FETCH     | request instruction, latch fields on instr_valid
// DECODE    | register decoded controls, pick EXEC or TRAP
// EXEC      | start M op, resolve branch, or route to MEM/WB
// EXEC_WAIT | wait for multi-cycle ALU (alu_done)
// MEM       | hold mem_req until dmem_ready or timeout
// WB        | register-file write and PC update
// TRAP      | illegal-instruction pulse and PC update
module multicycle_ctrl_fsm #(
    parameter int ENABLE_M    = 0,
    parameter int MEM_TIMEOUT = 255,
    parameter int ALU_CTRL_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    input  logic [6:0]            opcode,
    input  logic [2:0]            fun3,
    input  logic [6:0]            fun7,
    input  logic                  dmem_ready,
    input  logic                  alu_done,
    input  logic                  br_taken,
    output logic                  instr_req,
    output logic                  pc_en,
    output logic                  next_sel,
    output logic                  jalr_out,
    output logic                  branch,
    output logic                  reg_write,
    output logic                  operand_a,
    output logic                  operand_b,
    output logic [2:0]            imm_sel,
    output logic [1:0]            mem_to_reg,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  alu_start,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  illegal_instr,
    output logic                  bus_error
);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, EXEC_WAIT, MEM, WB, TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Counter only needs to reach MEM_TIMEOUT-1; the last MEM cycle is the compare hit.
    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [6:0]              opcode_q, opcode_d;
    logic [2:0]              fun3_q, fun3_d;
    logic [6:0]              fun7_q, fun7_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              imm_sel_q, imm_sel_d;
    logic                    opa_q, opa_d, opb_q, opb_d;
    logic [1:0]              m2r_q, m2r_d;
    logic [ALU_CTRL_W-1:0]   alu_q, alu_d;
    logic                    is_m_q, is_m_d, is_load_q, is_load_d, is_store_q, is_store_d;
    logic                    is_br_q, is_br_d, is_jal_q, is_jal_d, is_jalr_q, is_jalr_d;

    logic       dec_illegal, dec_m, dec_load, dec_store, dec_br, dec_jal, dec_jalr;
    logic [2:0] dec_imm;
    logic       dec_opa, dec_opb;
    logic [1:0] dec_m2r;
    logic [4:0] dec_alu;
    logic       instr_req_c;

    function automatic logic [4:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'b000:  alu_base = 5'd0;
            3'b001:  alu_base = 5'd2;
            3'b010:  alu_base = 5'd3;
            3'b011:  alu_base = 5'd4;
            3'b100:  alu_base = 5'd5;
            3'b101:  alu_base = 5'd6;
            3'b110:  alu_base = 5'd8;
            default: alu_base = 5'd9;
        endcase
    endfunction

    always_comb begin
        dec_illegal = 1'b0;
        dec_m       = 1'b0;
        dec_load    = 1'b0;
        dec_store   = 1'b0;
        dec_br      = 1'b0;
        dec_jal     = 1'b0;
        dec_jalr    = 1'b0;
        dec_imm     = IMM_I;
        dec_opa     = 1'b0;
        dec_opb     = 1'b0;
        dec_m2r     = 2'b00;
        dec_alu     = 5'd0;
        case (opcode_q)
            OP_R: begin
                case (fun7_q)
                    7'b0000000: dec_alu = alu_base(fun3_q);
                    7'b0100000: begin
                        if (fun3_q == 3'b000)      dec_alu = 5'd1;
                        else if (fun3_q == 3'b101) dec_alu = 5'd7;
                        else                       dec_illegal = 1'b1;
                    end
                    7'b0000001: begin
                        if (ENABLE_M != 0) begin
                            dec_m   = 1'b1;
                            dec_alu = 5'd16 + {2'b00, fun3_q};
                        end else begin
                            dec_illegal = 1'b1;
                        end
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec_opb = 1'b1;
                // Only the shift-immediates constrain fun7.
                case (fun3_q)
                    3'b001: begin
                        dec_alu = 5'd2;
                        if (fun7_q != 7'b0000000) dec_illegal = 1'b1;
                    end
                    3'b101: begin
                        if (fun7_q == 7'b0000000)      dec_alu = 5'd6;
                        else if (fun7_q == 7'b0100000) dec_alu = 5'd7;
                        else                           dec_illegal = 1'b1;
                    end
                    default: dec_alu = alu_base(fun3_q);
                endcase
            end
            OP_LOAD: begin
                dec_load = 1'b1;
                dec_opb  = 1'b1;
                dec_m2r  = 2'b01;
                if (fun3_q == 3'b011 || fun3_q == 3'b110 || fun3_q == 3'b111) dec_illegal = 1'b1;
            end
            OP_STORE: begin
                dec_store = 1'b1;
                dec_opb   = 1'b1;
                dec_imm   = IMM_S;
                if (fun3_q > 3'b010) dec_illegal = 1'b1;
            end
            OP_BRANCH: begin
                dec_br  = 1'b1;
                dec_imm = IMM_B;
                dec_opa = 1'b1;
                dec_opb = 1'b1;
                if (fun3_q == 3'b010 || fun3_q == 3'b011) dec_illegal = 1'b1;
            end
            OP_JAL: begin
                dec_jal = 1'b1;
                dec_imm = IMM_J;
                dec_opa = 1'b1;
                dec_opb = 1'b1;
                dec_m2r = 2'b10;
            end
            OP_JALR: begin
                dec_jalr = 1'b1;
                dec_opb  = 1'b1;
                dec_m2r  = 2'b10;
                if (fun3_q != 3'b000) dec_illegal = 1'b1;
            end
            OP_LUI: begin
                dec_imm = IMM_U;
                dec_opb = 1'b1;
                dec_alu = 5'd15;
            end
            OP_AUIPC: begin
                dec_imm = IMM_U;
                dec_opa = 1'b1;
                dec_opb = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        fun3_d     = fun3_q;
        fun7_d     = fun7_q;
        cnt_d      = cnt_q;
        imm_sel_d  = imm_sel_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        m2r_d      = m2r_q;
        alu_d      = alu_q;
        is_m_d     = is_m_q;
        is_load_d  = is_load_q;
        is_store_d = is_store_q;
        is_br_d    = is_br_q;
        is_jal_d   = is_jal_q;
        is_jalr_d  = is_jalr_q;

        instr_req_c   = 1'b0;
        pc_en         = 1'b0;
        next_sel      = 1'b0;
        jalr_out      = 1'b0;
        branch        = 1'b0;
        reg_write     = 1'b0;
        alu_start     = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        illegal_instr = 1'b0;
        bus_error     = 1'b0;

        case (state_q)
            FETCH: begin
                instr_req_c = 1'b1;
                if (instr_valid) begin
                    opcode_d = opcode;
                    fun3_d   = fun3;
                    fun7_d   = fun7;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                imm_sel_d  = dec_imm;
                opa_d      = dec_opa;
                opb_d      = dec_opb;
                m2r_d      = dec_m2r;
                alu_d      = ALU_CTRL_W'(dec_alu);
                is_m_d     = dec_m;
                is_load_d  = dec_load;
                is_store_d = dec_store;
                is_br_d    = dec_br;
                is_jal_d   = dec_jal;
                is_jalr_d  = dec_jalr;
                state_d    = dec_illegal ? TRAP : EXEC;
            end
            EXEC: begin
                if (is_m_q) begin
                    alu_start = 1'b1;
                    state_d   = EXEC_WAIT;
                end else if (is_load_q || is_store_q) begin
                    state_d = MEM;
                end else if (is_br_q) begin
                    pc_en   = 1'b1;
                    branch  = br_taken;
                    state_d = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            EXEC_WAIT: begin
                if (alu_done) state_d = WB;
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store_q;
                if (dmem_ready) begin
                    cnt_d = '0;
                    if (is_store_q) begin
                        pc_en   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    bus_error = 1'b1;
                    pc_en     = 1'b1;
                    cnt_d     = '0;
                    state_d   = FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB: begin
                reg_write = 1'b1;
                pc_en     = 1'b1;
                next_sel  = is_jal_q;
                jalr_out  = is_jalr_q;
                state_d   = FETCH;
            end
            TRAP: begin
                illegal_instr = 1'b1;
                pc_en         = 1'b1;
                state_d       = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Reset puts the FSM in FETCH; keep instr_req quiet while rst is held.
    assign instr_req   = instr_req_c & ~rst;
    assign operand_a   = opa_q;
    assign operand_b   = opb_q;
    assign imm_sel     = imm_sel_q;
    assign mem_to_reg  = m2r_q;
    assign alu_control = alu_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            opcode_q   <= '0;
            fun3_q     <= '0;
            fun7_q     <= '0;
            cnt_q      <= '0;
            imm_sel_q  <= '0;
            opa_q      <= 1'b0;
            opb_q      <= 1'b0;
            m2r_q      <= '0;
            alu_q      <= '0;
            is_m_q     <= 1'b0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            is_br_q    <= 1'b0;
            is_jal_q   <= 1'b0;
            is_jalr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            fun3_q     <= fun3_d;
            fun7_q     <= fun7_d;
            cnt_q      <= cnt_d;
            imm_sel_q  <= imm_sel_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            m2r_q      <= m2r_d;
            alu_q      <= alu_d;
            is_m_q     <= is_m_d;
            is_load_q  <= is_load_d;
            is_store_q <= is_store_d;
            is_br_q    <= is_br_d;
            is_jal_q   <= is_jal_d;
            is_jalr_q  <= is_jalr_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm. dut_a has the M extension enabled,
// dut_b has it disabled; both use a 4-cycle memory timeout and share stimulus.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] fun3 = '0;
    logic [6:0] fun7 = '0;
    logic       dmem_ready = 1'b0;
    logic       alu_done = 1'b0;
    logic       br_taken = 1'b0;

    logic       instr_req, pc_en, next_sel, jalr_out, branch, reg_write;
    logic       operand_a, operand_b, alu_start, mem_req, mem_we, illegal_instr, bus_error;
    logic [2:0] imm_sel;
    logic [1:0] mem_to_reg;
    logic [4:0] alu_control;

    logic       b_instr_req, b_pc_en, b_next_sel, b_jalr_out, b_branch, b_reg_write;
    logic       b_operand_a, b_operand_b, b_alu_start, b_mem_req, b_mem_we, b_illegal_instr, b_bus_error;
    logic [2:0] b_imm_sel;
    logic [1:0] b_mem_to_reg;
    logic [4:0] b_alu_control;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.ENABLE_M(1), .MEM_TIMEOUT(4), .ALU_CTRL_W(5)) dut_a (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .fun3(fun3), .fun7(fun7),
        .dmem_ready(dmem_ready), .alu_done(alu_done), .br_taken(br_taken),
        .instr_req(instr_req), .pc_en(pc_en), .next_sel(next_sel), .jalr_out(jalr_out),
        .branch(branch), .reg_write(reg_write), .operand_a(operand_a), .operand_b(operand_b),
        .imm_sel(imm_sel), .mem_to_reg(mem_to_reg), .alu_control(alu_control),
        .alu_start(alu_start), .mem_req(mem_req), .mem_we(mem_we),
        .illegal_instr(illegal_instr), .bus_error(bus_error)
    );

    multicycle_ctrl_fsm #(.ENABLE_M(0), .MEM_TIMEOUT(4), .ALU_CTRL_W(5)) dut_b (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .fun3(fun3), .fun7(fun7),
        .dmem_ready(dmem_ready), .alu_done(alu_done), .br_taken(br_taken),
        .instr_req(b_instr_req), .pc_en(b_pc_en), .next_sel(b_next_sel), .jalr_out(b_jalr_out),
        .branch(b_branch), .reg_write(b_reg_write), .operand_a(b_operand_a), .operand_b(b_operand_b),
        .imm_sel(b_imm_sel), .mem_to_reg(b_mem_to_reg), .alu_control(b_alu_control),
        .alu_start(b_alu_start), .mem_req(b_mem_req), .mem_we(b_mem_we),
        .illegal_instr(b_illegal_instr), .bus_error(b_bus_error)
    );

    logic [22:0] all_out;
    assign all_out = {instr_req, pc_en, next_sel, jalr_out, branch, reg_write, operand_a, operand_b,
                      imm_sel, mem_to_reg, alu_control, alu_start, mem_req, mem_we,
                      illegal_instr, bus_error};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Presents an instruction in FETCH for one cycle; returns in DECODE.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode      = op;
        fun3        = f3;
        fun7        = f7;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] alu;
        logic       trap;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{op: 7'b0110011, f3: 3'b000, f7: 7'b0100000, alu: 5'd1,  trap: 1'b0}; // SUB
        vecs[1] = '{op: 7'b0110011, f3: 3'b011, f7: 7'b0000000, alu: 5'd4,  trap: 1'b0}; // SLTU
        vecs[2] = '{op: 7'b0110011, f3: 3'b111, f7: 7'b0000000, alu: 5'd9,  trap: 1'b0}; // AND
        vecs[3] = '{op: 7'b0010011, f3: 3'b101, f7: 7'b0100000, alu: 5'd7,  trap: 1'b0}; // SRAI
        vecs[4] = '{op: 7'b0110111, f3: 3'b000, f7: 7'b0000000, alu: 5'd15, trap: 1'b0}; // LUI
        vecs[5] = '{op: 7'b0010111, f3: 3'b000, f7: 7'b0000000, alu: 5'd0,  trap: 1'b0}; // AUIPC
        vecs[6] = '{op: 7'b1100111, f3: 3'b000, f7: 7'b0000000, alu: 5'd0,  trap: 1'b0}; // JALR
        vecs[7] = '{op: 7'b0110011, f3: 3'b001, f7: 7'b0100000, alu: 5'd0,  trap: 1'b1}; // bad R
        vecs[8] = '{op: 7'b1100011, f3: 3'b010, f7: 7'b0000000, alu: 5'd0,  trap: 1'b1}; // bad branch
        vecs[9] = '{op: 7'b0010011, f3: 3'b001, f7: 7'b0100000, alu: 5'd0,  trap: 1'b1}; // bad SLLI

        #1;
        chk("reset_outputs", 32'(all_out), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("fetch_instr_req", 32'(instr_req), 1);

        // ADD with instr_valid held: FETCH(1) DECODE(2) EXEC(3) WB(4)
        opcode = 7'b0110011; fun3 = 3'b000; fun7 = 7'b0000000; instr_valid = 1'b1;
        tick();
        chk("add_decode_req", 32'(instr_req), 0);
        tick();
        chk("add_exec_alu", 32'(alu_control), 0);
        chk("add_exec_rw", 32'(reg_write), 0);
        tick();
        chk("add_wb_rw", 32'(reg_write), 1);
        chk("add_wb_pc", 32'(pc_en), 1);
        instr_valid = 1'b0;
        tick();
        chk("add_fetch_req", 32'(instr_req), 1);
        chk("add_fetch_rw", 32'(reg_write), 0);

        // LW, dmem_ready in third MEM cycle
        issue(7'b0000011, 3'b010, 7'b0);
        tick();
        tick();
        chk("lw_mem1_req", 32'(mem_req), 1);
        chk("lw_m2r", 32'(mem_to_reg), 1);
        chk("lw_we", 32'(mem_we), 0);
        tick();
        chk("lw_mem2_req", 32'(mem_req), 1);
        tick();
        chk("lw_mem3_req", 32'(mem_req), 1);
        dmem_ready = 1'b1;
        #1;
        chk("lw_mem3_rw", 32'(reg_write), 0);
        tick();
        dmem_ready = 1'b0;
        chk("lw_wb_rw", 32'(reg_write), 1);
        chk("lw_wb_req", 32'(mem_req), 0);
        tick();

        // SW, ready in first MEM cycle
        issue(7'b0100011, 3'b010, 7'b0);
        tick();
        tick();
        chk("sw_we", 32'(mem_we), 1);
        chk("sw_imm", 32'(imm_sel), 1);
        dmem_ready = 1'b1;
        #1;
        chk("sw_pc", 32'(pc_en), 1);
        chk("sw_rw", 32'(reg_write), 0);
        tick();
        dmem_ready = 1'b0;
        chk("sw_fetch_req", 32'(instr_req), 1);
        chk("sw_fetch_rw", 32'(reg_write), 0);

        // LW timeout: bus_error on 4th MEM cycle
        issue(7'b0000011, 3'b010, 7'b0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("to_mem%0d_req", i), 32'(mem_req), 1);
            chk($sformatf("to_mem%0d_berr", i), 32'(bus_error), (i == 4) ? 1 : 0);
            chk($sformatf("to_mem%0d_rw", i), 32'(reg_write), 0);
        end
        chk("to_pc", 32'(pc_en), 1);
        tick();
        chk("to_fetch_req", 32'(instr_req), 1);
        chk("to_fetch_berr", 32'(bus_error), 0);
        chk("to_fetch_rw", 32'(reg_write), 0);

        // LW with dmem_ready on the timeout cycle
        issue(7'b0000011, 3'b010, 7'b0);
        tick();
        tick();
        tick();
        tick();
        tick();
        dmem_ready = 1'b1;
        #1;
        chk("tr_berr", 32'(bus_error), 0);
        tick();
        dmem_ready = 1'b0;
        chk("tr_wb_rw", 32'(reg_write), 1);
        tick();

        // MUL: dut_a waits on alu_done, dut_b traps
        issue(7'b0110011, 3'b000, 7'b0000001);
        tick();
        chk("mul_alu", 32'(alu_control), 16);
        chk("mul_start", 32'(alu_start), 1);
        chk("mul_nm_illegal", 32'(b_illegal_instr), 1);
        chk("mul_nm_rw", 32'(b_reg_write), 0);
        tick();
        chk("mul_start_pulse", 32'(alu_start), 0);
        chk("mul_nm_illegal_pulse", 32'(b_illegal_instr), 0);
        tick();
        tick();
        chk("mul_wait_rw", 32'(reg_write), 0);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("mul_wb_rw", 32'(reg_write), 1);
        chk("mul_nm_no_rw", 32'(b_reg_write), 0);
        tick();

        // BEQ taken / not taken
        for (int t = 1; t >= 0; t--) begin
            issue(7'b1100011, 3'b000, 7'b0);
            tick();
            br_taken = t[0];
            #1;
            chk($sformatf("beq%0d_pc", t), 32'(pc_en), 1);
            chk($sformatf("beq%0d_branch", t), 32'(branch), t);
            chk($sformatf("beq%0d_imm", t), 32'(imm_sel), 2);
            chk($sformatf("beq%0d_opa", t), 32'(operand_a), 1);
            chk($sformatf("beq%0d_rw", t), 32'(reg_write), 0);
            tick();
            br_taken = 1'b0;
            chk($sformatf("beq%0d_fetch_pc", t), 32'(pc_en), 0);
        end

        // JAL
        issue(7'b1101111, 3'b000, 7'b0);
        tick();
        chk("jal_m2r", 32'(mem_to_reg), 2);
        chk("jal_imm", 32'(imm_sel), 3);
        tick();
        chk("jal_wb_next", 32'(next_sel), 1);
        chk("jal_wb_jalr", 32'(jalr_out), 0);
        chk("jal_wb_rw", 32'(reg_write), 1);
        tick();
        chk("jal_fetch_next", 32'(next_sel), 0);

        // Decode table
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].f3, vecs[i].f7);
            tick();
            chk($sformatf("vec%0d_illegal", i), 32'(illegal_instr), 32'(vecs[i].trap));
            if (vecs[i].trap) begin
                chk($sformatf("vec%0d_trap_rw", i), 32'(reg_write), 0);
                tick();
            end else begin
                chk($sformatf("vec%0d_alu", i), 32'(alu_control), 32'(vecs[i].alu));
                tick();
                chk($sformatf("vec%0d_wb_rw", i), 32'(reg_write), 1);
                tick();
            end
            chk($sformatf("vec%0d_fetch", i), 32'(instr_req), 1);
        end

        // Reset during MEM aborts everything
        issue(7'b0000011, 3'b010, 7'b0);
        tick();
        tick();
        chk("rst_pre_req", 32'(mem_req), 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", 32'(all_out), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_rel_req", 32'(instr_req), 1);
        tick();
        chk("rst_rel_rw", 32'(reg_write), 0);

        // Unknown opcode traps
        issue(7'b1111111, 3'b000, 7'b0);
        tick();
        chk("bad_op_illegal", 32'(illegal_instr), 1);
        chk("bad_op_pc", 32'(pc_en), 1);
        chk("bad_op_rw", 32'(reg_write), 0);
        tick();
        chk("bad_op_pulse", 32'(illegal_instr), 0);
        chk("bad_op_fetch", 32'(instr_req), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Parametrised multi-cycle control sequencer for the RV32I core. It replaces the single-cycle combinational decoder and the external load-stall inputs with an explicit FSM covering fetch, decode, execute, memory and writeback. It adds data-memory handshaking with a timeout, optional M-extension decode with a multi-cycle ALU wait, and illegal-instruction trapping. It sits between the fetch unit, register file, ALU and data-memory interface.

Parameters:
ENABLE_M, 0, 1 = decode MUL/DIV/REM (fun7=0000001) and wait on alu_done
MEM_TIMEOUT, 255, max cycles mem_req is held without dmem_ready before bus_error (≥1)
ALU_CTRL_W, 5, alu_control width (≥5)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
instr_valid  in  1  fetched instruction available
opcode  in  7  instr[6:0], sampled in FETCH when instr_valid=1
fun3  in  3  instr[14:12]
fun7  in  7  instr[31:25]
dmem_ready  in  1  data-memory access complete
alu_done  in  1  multi-cycle ALU op finished
br_taken  in  1  branch comparison result, valid in EXEC
instr_req  out  1  request next instruction
pc_en  out  1  one-cycle PC update strobe
next_sel  out  1  PC source = jal target
jalr_out  out  1  PC source = jalr target
branch  out  1  PC source = branch target (qualified by br_taken)
reg_write  out  1  one-cycle RF write strobe
operand_a  out  1  ALU A = PC
operand_b  out  1  ALU B = immediate
imm_sel  out  3  I=000 S=001 B=010 J=011 U=100
mem_to_reg  out  2  00 ALU, 01 memory, 10 PC+4
alu_control  out  ALU_CTRL_W  operation code
alu_start  out  1  one-cycle start pulse for M ops
mem_req  out  1  data-memory request, level
mem_we  out  1  store when 1
illegal_instr  out  1  one-cycle trap pulse
bus_error  out  1  one-cycle timeout pulse

Behaviour:
- States: FETCH, DECODE, EXEC, EXEC_WAIT, MEM, WB, TRAP. On rst: state=FETCH, all outputs 0, instruction fields cleared, timeout counter=0.
- FETCH: instr_req=1. On instr_valid=1, latch opcode/fun3/fun7 → DECODE; otherwise hold.
- DECODE (1 cycle): register the type decode and imm_sel/operand_a/operand_b/mem_to_reg/alu_control; these stay stable until the next DECODE.
- Illegal cases go to TRAP. These are: an unknown opcode, an undefined fun3/fun7 pair, or M ops when ENABLE_M=0.
- Otherwise go to EXEC.
- alu_control codes, zero-extended to ALU_CTRL_W: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, LUI-pass 15.
- M ops use 16+fun3. Load, store, branch, jal, jalr and auipc use ADD. I-type SRAI uses fun7=0100000; SUB and SRA use fun7=0100000.
- EXEC: M op → alu_start=1 for one cycle → EXEC_WAIT. Load/store → MEM. Branch → pc_en=1 and branch=br_taken → FETCH. All others → WB.
- EXEC_WAIT: hold until alu_done=1 → WB. There is no timeout in this state.
- MEM: mem_req=1 (mem_we=1 for store), and the counter increments each cycle.
  - dmem_ready=1: load → WB; store → pc_en=1 → FETCH.
  - Counter reaching MEM_TIMEOUT without dmem_ready: bus_error=1, pc_en=1, no write → FETCH.
  - dmem_ready takes priority over timeout in the same cycle.
  - The counter clears on MEM exit.
- WB (1 cycle): reg_write=1 and pc_en=1. next_sel=jal and jalr_out=jalr for this cycle → FETCH.
- TRAP (1 cycle): illegal_instr=1, pc_en=1, reg_write=0 → FETCH.
- pc_en, reg_write, alu_start, illegal_instr and bus_error are single-cycle pulses.
- rst asserted mid-operation aborts immediately: mem_req drops asynchronously and no pending write occurs.

Test Plan:
- ADD (op 0110011, fun3 000, fun7 0) with instr_valid held → DECODE, EXEC, WB; reg_write at cycle 4 after valid; alu_control=0; the following FETCH asserts instr_req.
- LW (0000011, fun3 010), dmem_ready after 3 cycles → mem_req high 3 cycles, mem_to_reg=01, reg_write in WB; SW → mem_we=1, no reg_write.
- LW with MEM_TIMEOUT=4 and dmem_ready never → bus_error pulse after 4 MEM cycles, reg_write never asserted, return to FETCH; dmem_ready arriving on the timeout cycle → no bus_error, WB occurs.
- ENABLE_M=1, MUL (fun7 0000001, fun3 000) → alu_control=16, alu_start 1-cycle pulse, WB only after alu_done; ENABLE_M=0 same instruction → illegal_instr pulse, no write.
- BEQ with br_taken=1/0 → pc_en pulse with branch=1/0, imm_sel=010, operand_a=1, no reg_write; JAL → mem_to_reg=10, next_sel=1 in WB.
- Assert rst during MEM with mem_req=1 → all outputs 0 immediately, FETCH after release; opcode 1111111 → TRAP pulse.
